// File: rtl/board_cell_painter.sv
// board_cell_painter: repaints the nine tic-tac-toe cells as filled squares into a 160x120 VGA adapter.
// Optional black outline per cell when BOARD_CELL_PAINTER_BORDER_EN is defined.
module board_cell_painter #(
    parameter int CELL_SIZE = 26,
    parameter int CNT_W     = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cell_x,
    input  logic [6:0] cell_y,
    input  logic [2:0] cell_colour,
    output logic [3:0] cell_idx,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] DRAW   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CELL_SIZE - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] dx, dy;
    logic [7:0]       ox;
    logic [6:0]       oy;
    logic [2:0]       col;
    logic             row_end, cell_end;
    logic [2:0]       pix_col;

    assign row_end  = dx == LAST;
    assign cell_end = row_end && dy == LAST;
`ifdef BOARD_CELL_PAINTER_BORDER_EN
    assign pix_col = (dx == '0 || row_end || dy == '0 || dy == LAST) ? 3'b000 : col;
`else
    assign pix_col = col;
`endif

    // outputs are registered from the current state, so pixels appear one cycle after their DRAW cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cell_idx   <= '0;
            dx         <= '0;
            dy         <= '0;
            ox         <= '0;
            oy         <= '0;
            col        <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= state == DRAW;
            done <= state == FINISH;
            busy <= (state == IDLE && start) || state == LOAD || state == DRAW;
            if (state == DRAW) begin
                vga_x      <= ox + 8'(dx);
                vga_y      <= oy + 7'(dy);
                vga_colour <= pix_col;
            end
            case (state)
                IDLE: begin
                    cell_idx <= '0;
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    ox    <= cell_x;
                    oy    <= cell_y;
                    col   <= cell_colour;
                    dx    <= '0;
                    dy    <= '0;
                    state <= DRAW;
                end
                DRAW: begin
                    dx <= row_end ? '0 : dx + 1'b1;
                    if (row_end) dy <= dy + 1'b1;
                    if (cell_end) begin
                        if (cell_idx < 4'd8) begin
                            cell_idx <= cell_idx + 4'd1;
                            state    <= LOAD;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                default: begin
                    cell_idx <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_cell_painter.sv
// tb_board_cell_painter: randomized and directed repaints checked against a cell/pixel reference model.
module tb_board_cell_painter;
    localparam int S   = 4;
    localparam int TOT = 9 * (1 + S * S) + 1;

    typedef struct {int c; int x; int y; int col;} pix_t;
    typedef struct {int c; bit plot; int x; int y; int col; bit done; bit busy; int idx;} samp_t;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [17:0] grid = '0;
    logic [7:0]  cell_x, vga_x;
    logic [6:0]  cell_y, vga_y;
    logic [2:0]  cell_colour, vga_colour;
    logic [3:0]  cell_idx;
    logic        plot, busy, done;
    int          cyc = 0, tests = 0, fails = 0;
    samp_t       log_q[$];

    board_cell_painter #(.CELL_SIZE(S), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cell_x(cell_x), .cell_y(cell_y), .cell_colour(cell_colour),
        .cell_idx(cell_idx), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic int code_of(input logic [17:0] g, input int k);
        return (k > 8) ? 0 : int'((g >> (2 * (8 - k))) & 18'h3);
    endfunction

    function automatic int col_of(input int c);
        return c == 0 ? 7 : c == 1 ? 3 : c == 2 ? 5 : 0;
    endfunction

    always_comb begin
        cell_x      = 8'(37 + 30 * (int'(cell_idx) % 3));
        cell_y      = 7'(7 + 30 * (int'(cell_idx) / 3));
        cell_colour = 3'(col_of(code_of(grid, int'(cell_idx))));
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock)
        log_q.push_back('{cyc, plot, int'(vga_x), int'(vga_y), int'(vga_colour), done, busy, int'(cell_idx)});

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, int'({plot, busy, done, cell_idx, vga_x, vga_y, vga_colour}), 0);
    endtask

    task automatic repaint(input string tag, input logic [17:0] g0, input logic [17:0] g1,
                           input int chg_off, input int sp_off);
        int c0, n, bad, d, dc, bb, ib, eb;
        pix_t e[$];
        @(negedge clock);
        grid  = g0;
        start = 1'b1;
        @(posedge clock);
        #1 c0 = cyc;
        for (int k = 0; k < 9; k++) begin
            int code = code_of((chg_off >= 0 && k * (S * S + 1) >= chg_off) ? g1 : g0, k);
            for (int y = 0; y < S; y++)
                for (int x = 0; x < S; x++) begin
                    int colr = col_of(code);
`ifdef BOARD_CELL_PAINTER_BORDER_EN
                    if (x == 0 || y == 0 || x == S - 1 || y == S - 1) colr = 0;
`endif
                    e.push_back('{c0 + 2 + k * (S * S + 1) + y * S + x,
                                  37 + 30 * (k % 3) + x, 7 + 30 * (k / 3) + y, colr});
                end
        end
        repeat (TOT + 4) begin
            @(negedge clock);
            if (chg_off >= 0 && cyc == c0 + chg_off) grid = g1;
            start = sp_off >= 0 && cyc == c0 + sp_off;
        end
        @(posedge clock);
        n = 0; bad = 0; d = 0; dc = -1; bb = 0; ib = 0; eb = 0;
        foreach (log_q[i]) begin
            samp_t s = log_q[i];
            if (s.c < c0 || s.c > c0 + TOT + 3) continue;
            if (s.plot) begin
                if (n >= e.size() || s.c != e[n].c || s.x != e[n].x || s.y != e[n].y || s.col != e[n].col) bad++;
                n++;
            end
            if (s.done) begin d++; dc = s.c; end
            if (s.c >= c0 + 1 && s.c <= c0 + TOT - 1 && !s.busy) bb++;
            if ((s.c - c0) % (S * S + 1) == 0 && (s.c - c0) / (S * S + 1) < 9 && s.idx != (s.c - c0) / (S * S + 1)) ib++;
            if (s.c == c0 + TOT && (s.busy || s.idx != 0 || s.plot)) eb++;
        end
        chk({tag, "_plot_count"}, n, 9 * S * S);
        chk({tag, "_pixels"}, bad, 0);
        chk({tag, "_done_count"}, d, 1);
        chk({tag, "_done_cycle"}, dc - c0, TOT);
        chk({tag, "_busy_gap"}, bb, 0);
        chk({tag, "_load_idx"}, ib, 0);
        chk({tag, "_end_state"}, eb, 0);
    endtask

    initial begin
        int c0, rc, n, d, d0, d1;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk_idle("reset_hold");
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk_idle("reset_release");

        repaint("empty", '0, '0, -1, -1);
        repaint("x4_o0", 18'h10200, '0, -1, -1);
        repaint("start_mid3", 18'h10200, '0, -1, 3 * (S * S + 1) + 5);
        repeat (3) repaint("random", 18'($urandom), '0, -1, -1);
        repaint("grid_change", 18'($urandom), 18'($urandom), 2 * (S * S + 1) + 7, -1);

        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 c0 = cyc;
        @(negedge clock);
        start = 1'b0;
        rc = c0 + 5 * (S * S + 1) + 6;
        while (cyc < rc) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_idle("reset_mid_draw");
        reset = 1'b0;
        repeat (TOT) @(negedge clock);
        @(posedge clock);
        n = 0; d = 0;
        foreach (log_q[i]) begin
            if (log_q[i].c > rc && log_q[i].plot) n++;
            if (log_q[i].c >= c0 && log_q[i].done) d++;
        end
        chk("reset_mid_plots", n, 0);
        chk("reset_mid_done", d, 0);
        repaint("after_reset", '0, '0, -1, -1);

        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 c0 = cyc;
        repeat (2 * TOT + 2) @(negedge clock);
        start = 1'b0;
        repeat (TOT + 4) @(negedge clock);
        @(posedge clock);
        d = 0; d0 = -1; d1 = -1;
        foreach (log_q[i]) begin
            if (log_q[i].c >= c0 && log_q[i].done) begin
                if (d == 0) d0 = log_q[i].c;
                if (d == 1) d1 = log_q[i].c;
                d++;
            end
        end
        chk("held_done_count", d, 2);
        chk("held_first_done", d0 - c0, TOT);
        chk("held_restart_gap", d1 - d0, TOT + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/board_cell_painter.md
Name: board_cell_painter

Overview:
- Downstream consumer of the tic-tac-toe cell position/colour decoder.
- On `start`, walks cells 0..8 in order, one cell at a time:
  - drives `cell_idx` to the decoder;
  - latches the decoder's pixel origin and colour;
  - rasterises a filled CELL_SIZE x CELL_SIZE square, one pixel per cycle, into the 160x120 VGA adapter.
- Cell 0 = grid[17:16] = top-left at origin (37,7); cell 8 = grid[1:0] = bottom-right at (97,67); pitch 30 px.

Parameters:
- CELL_SIZE, 26, square side in pixels; legal range 2..30. CELL_SIZE > 30 overlaps neighbouring cells.
- CNT_W, 5, width of the dx/dy counters; must satisfy 2^CNT_W >= CELL_SIZE.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a full board repaint; sampled only in IDLE.
- cell_x  in  8  cell origin x from decoder for the current cell_idx.
- cell_y  in  7  cell origin y from decoder.
- cell_colour  in  3  cell colour from decoder (111 empty, 011 O, 101 X).
- cell_idx  out  4  cell currently selected for the decoder, 0..8.
- vga_x  out  8  pixel x to VGA adapter.
- vga_y  out  7  pixel y to VGA adapter.
- vga_colour  out  3  pixel colour.
- plot  out  1  write-enable to VGA adapter; one pixel per high cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final pixel of cell 8.

Behaviour:
- Reset (synchronous, active-high, any state):
  - next state IDLE;
  - cell_idx=0, dx=dy=0;
  - vga_x=0, vga_y=0, vga_colour=0;
  - plot=0, busy=0, done=0.
- All outputs come from registers; no combinational path from inputs to outputs.
- IDLE:
  - plot=0, busy=0, cell_idx=0.
  - start=1 at an edge moves to LOAD; busy=1 from the next cycle.
- LOAD (1 cycle):
  - cell_idx is held stable; the decoder is combinational.
  - At the end of the cycle, latch cell_x, cell_y, cell_colour into ox, oy, col; clear dx and dy.
  - Next state DRAW.
- DRAW (CELL_SIZE^2 cycles per cell):
  - plot=1, vga_x=ox+dx, vga_y=oy+dy, vga_colour=col.
  - Scan order is row-major: dx increments each cycle. When dx=CELL_SIZE-1, dx wraps to 0 and dy increments.
  - At dx=dy=CELL_SIZE-1:
    - if cell_idx<8, increment cell_idx and go to LOAD;
    - otherwise go to FINISH.
- FINISH (1 cycle): plot=0, done=1, busy=0 in this cycle. Next state IDLE with cell_idx=0.
- Timing: first plot occurs 2 cycles after the start edge. Total plot cycles = 9*CELL_SIZE^2. Start edge to done = 9*(1+CELL_SIZE^2)+1 cycles.
- Arithmetic:
  - ox+dx is 8-bit and oy+dy is 7-bit, unsigned.
  - The legal CELL_SIZE range guarantees no overflow: max x = 97+29 = 126, max y = 67+29 = 96.
- start while busy (LOAD/DRAW/FINISH) is ignored and never queued.
- start held high continuously: a new repaint begins in the cycle after FINISH (IDLE accepts it immediately).
- The grid may change mid-repaint. Each cell uses the decoder values captured in its own LOAD cycle; cells already drawn are not revisited.
- Reset asserted mid-DRAW:
  - plot drops to 0 on the next edge and no further pixels are written;
  - no done pulse is produced;
  - a later start restarts at cell 0.
- Decoder output for an unsupported code (grid pair 2'd3) is passed through as latched; no checking in this block.

Optional Feature:
- Macro: BOARD_CELL_PAINTER_BORDER_EN.
- Defined: during DRAW, any pixel with dx==0, dx==CELL_SIZE-1, dy==0 or dy==CELL_SIZE-1 gets vga_colour=3'b000 (black outline). Interior pixels get col. Timing and pixel count are unchanged.
- Undefined: every pixel gets col; no border logic is synthesised.

Test Plan:
- Reset: hold reset 3 cycles with start=1 -> plot=0, busy=0, done=0, cell_idx=0, vga_x=vga_y=vga_colour=0 throughout and on the first edge after release.
- Full repaint, CELL_SIZE=4, behavioural decoder model, all cells empty: pulse start ->
  - first plot (37,7,111) two cycles later;
  - last plot (100,70,111);
  - exactly 144 plot cycles;
  - done high exactly one cycle, 154 cycles after the start edge.
- Colour mapping, CELL_SIZE=4: cell 4 = X, cell 0 = O ->
  - all 16 pixels in x 67..70, y 37..40 are 101;
  - pixels x 37..40, y 7..10 are 011;
  - all others 111;
  - cell_idx sequence observed in LOAD cycles is 0,1,...,8.
- start pulsed again mid-cell 3 -> ignored; total plot count 144; one done pulse; busy stays high continuously.
- Reset asserted during cell 5 DRAW ->
  - plot=0 from the next edge, no done;
  - a new start gives first plot at (37,7) with cell_idx=0.
- BOARD_CELL_PAINTER_BORDER_EN defined, CELL_SIZE=4, all empty -> (37,7) and (40,10) are 000; (38,8) and (39,9) are 111; 144 plot cycles unchanged.
